// File: rtl/data_sram_responder.sv
// data_sram_responder
//   Responder side of the core's like-SRAM data interface. Accepted requests
//   drive a single-port synchronous RAM (1-cycle read latency). Responses come
//   back strictly in acceptance order through a DEPTH-entry response FIFO,
//   each held back RESP_DELAY extra cycles before data_ok.
//
//   Parameters: DEPTH (max outstanding, power of two >= 2), RESP_DELAY (0..15),
//               RAM_AW (RAM word-address width).
//   Ports:
//     clk, rstn                       clock, async active-low reset
//     data_sram_req/wr/size/addr/wstrb/wdata   request from Execute
//     data_sram_addr_ok               request accepted this cycle (when req=1)
//     data_sram_data_ok/rdata         in-order one-cycle response pulse + data
//     ram_en/we/addr/wdata, ram_rdata data RAM port
//
//   Optional: define DATA_SRAM_RAND_STALL_EN to gate addr_ok with a 16-bit
//   LFSR (seed 16'hACE1) for handshake stress; ordering and data unchanged.
module data_sram_responder #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned RESP_DELAY = 0,
  parameter int unsigned RAM_AW     = 14
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              data_sram_req,
  input  logic              data_sram_wr,
  input  logic [1:0]        data_sram_size,
  input  logic [31:0]       data_sram_addr,
  input  logic [3:0]        data_sram_wstrb,
  input  logic [31:0]       data_sram_wdata,
  output logic              data_sram_addr_ok,
  output logic              data_sram_data_ok,
  output logic [31:0]       data_sram_rdata,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam int unsigned   PW      = $clog2(DEPTH);
  localparam int unsigned   CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [3:0]    DLY_C   = 4'(RESP_DELAY);

  logic [CW-1:0] out_cnt, out_cnt_nxt;
  logic          addr_ok_q, addr_ok_nxt;
  logic          accept;
  logic          s1_valid, s1_wr;
  logic [31:0]   fifo_data [DEPTH];
  logic [3:0]    fifo_dly  [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fifo_n;
  logic          head_valid, pop;

  // size and the byte-offset/high address bits carry no information here
  logic unused_bits;
  assign unused_bits = ^{data_sram_size, data_sram_addr[31:RAM_AW+2], data_sram_addr[1:0]};

  assign accept     = data_sram_req & addr_ok_q;
  assign head_valid = (fifo_n != '0);
  assign pop        = head_valid && (fifo_dly[rd_ptr] == '0);

  assign data_sram_addr_ok = addr_ok_q;
  assign data_sram_data_ok = pop;
  assign data_sram_rdata   = head_valid ? fifo_data[rd_ptr] : '0;

  assign ram_en    = accept;
  assign ram_we    = (accept && data_sram_wr) ? data_sram_wstrb : 4'b0;
  assign ram_addr  = accept ? data_sram_addr[RAM_AW+1:2] : '0;
  assign ram_wdata = accept ? data_sram_wdata : '0;

  always_comb begin
    out_cnt_nxt = out_cnt;
    if (accept && !pop)
      out_cnt_nxt = out_cnt + CW'(1);
    else if (!accept && pop)
      out_cnt_nxt = out_cnt - CW'(1);
  end

  // addr_ok is registered from next-state count so it reads as (count < DEPTH)
  // on the current state while still resetting to 0.
`ifdef DATA_SRAM_RAND_STALL_EN
  logic [15:0] lfsr, lfsr_nxt;
  assign lfsr_nxt    = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign addr_ok_nxt = (out_cnt_nxt < DEPTH_C) & lfsr_nxt[0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) lfsr <= 16'hACE1;
    else       lfsr <= lfsr_nxt;
  end
`else
  assign addr_ok_nxt = (out_cnt_nxt < DEPTH_C);
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_cnt   <= '0;
      addr_ok_q <= 1'b0;
      s1_valid  <= 1'b0;
      s1_wr     <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_n    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_dly[i]  <= '0;
      end
    end else begin
      out_cnt   <= out_cnt_nxt;
      addr_ok_q <= addr_ok_nxt;
      s1_valid  <= accept;
      s1_wr     <= data_sram_wr;
      // Every slot's delay counts down; the slot being filled is loaded instead.
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (s1_valid && (wr_ptr == PW'(i))) begin
          fifo_data[i] <= s1_wr ? '0 : ram_rdata;
          fifo_dly[i]  <= DLY_C;
        end else if (fifo_dly[i] != '0) begin
          fifo_dly[i] <= fifo_dly[i] - 4'd1;
        end
      end
      if (s1_valid) wr_ptr <= wr_ptr + PW'(1);
      if (pop)      rd_ptr <= rd_ptr + PW'(1);
      if (s1_valid && !pop)      fifo_n <= fifo_n + CW'(1);
      else if (!s1_valid && pop) fifo_n <= fifo_n - CW'(1);
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: two instances (RESP_DELAY 0 and 3) share one
// request stream; a queue-based model checks every cycle, and directed
// literals pin latencies, stall points and returned data.
module tb_data_sram_responder;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned RAW   = 14;

  typedef struct { int due; logic [31:0] d; } rsp_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic        req_wr;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic [1:0]  req_size = 2'd2;
  logic [1:0]  pend;

  wire  [1:0]     aok, dok, ren;
  wire  [3:0]     rwe   [2];
  wire  [RAW-1:0] raddr [2];
  wire  [31:0]    rdat  [2];
  wire  [31:0]    rwd   [2];
  logic [31:0]    rq0, rq1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int live [2];

  rsp_t mq0[$], mq1[$];
  logic [31:0] mmem [int];
  int acc0_q[$], acc1_q[$], dok0_c[$], dok1_c[$];
  logic [31:0] dok0_d[$], dok1_d[$];
  logic [3:0] acc0_we;
  logic [RAW-1:0] acc0_ad;

  data_sram_responder #(.DEPTH(DEPTH), .RESP_DELAY(0), .RAM_AW(RAW)) dut0 (
    .clk(clk), .rstn(rstn), .data_sram_req(pend[0]), .data_sram_wr(req_wr),
    .data_sram_size(req_size), .data_sram_addr(req_addr), .data_sram_wstrb(req_wstrb),
    .data_sram_wdata(req_wdata), .data_sram_addr_ok(aok[0]), .data_sram_data_ok(dok[0]),
    .data_sram_rdata(rdat[0]), .ram_en(ren[0]), .ram_we(rwe[0]), .ram_addr(raddr[0]),
    .ram_wdata(rwd[0]), .ram_rdata(rq0));

  data_sram_responder #(.DEPTH(DEPTH), .RESP_DELAY(3), .RAM_AW(RAW)) dut1 (
    .clk(clk), .rstn(rstn), .data_sram_req(pend[1]), .data_sram_wr(req_wr),
    .data_sram_size(req_size), .data_sram_addr(req_addr), .data_sram_wstrb(req_wstrb),
    .data_sram_wdata(req_wdata), .data_sram_addr_ok(aok[1]), .data_sram_data_ok(dok[1]),
    .data_sram_rdata(rdat[1]), .ram_en(ren[1]), .ram_we(rwe[1]), .ram_addr(raddr[1]),
    .ram_wdata(rwd[1]), .ram_rdata(rq1));

  // Synchronous RAMs, 1-cycle read latency
  logic [31:0] ram0 [16384];
  logic [31:0] ram1 [16384];
  always @(posedge clk) if (ren[0]) begin
    for (int b = 0; b < 4; b++) if (rwe[0][b]) ram0[raddr[0]][8*b +: 8] <= rwd[0][8*b +: 8];
    rq0 <= ram0[raddr[0]];
  end
  always @(posedge clk) if (ren[1]) begin
    for (int b = 0; b < 4; b++) if (rwe[1][b]) ram1[raddr[1]][8*b +: 8] <= rwd[1][8*b +: 8];
    rq1 <= ram1[raddr[1]];
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] cyc=%0d got=%h want=%h", nm, k, cyc, act, exp);
    end
  endtask

  function automatic int qsize(input int k);
    return (k == 0) ? mq0.size() : mq1.size();
  endfunction

  function automatic rsp_t qhead(input int k);
    return (k == 0) ? mq0[0] : mq1[0];
  endfunction

  task automatic qpop(input int k);
    if (k == 0) void'(mq0.pop_front()); else void'(mq1.pop_front());
  endtask

  task automatic qpush(input int k, input rsp_t r);
    if (k == 0) mq0.push_back(r); else mq1.push_back(r);
  endtask

  // Model: outstanding = queued responses; a response is due 2+delay cycles
  // after acceptance and leaves one per cycle in order.
  task automatic model_step(input int k);
    logic e_aok, e_dok, acc;
    rsp_t h, r;
    int key;
    logic [31:0] m;
    if (!rstn) begin
      live[k] = 0;
      if (k == 0) mq0.delete(); else mq1.delete();
      return;
    end
    if (live[k] < 2) live[k]++;
    e_aok = (live[k] >= 2) && (qsize(k) < DEPTH);
    chk("addr_ok", k, 32'(aok[k]), 32'(e_aok));
    e_dok = 1'b0;
    if (qsize(k) != 0) begin
      h = qhead(k);
      e_dok = (h.due <= cyc);
    end
    chk("data_ok", k, 32'(dok[k]), 32'(e_dok));
    if (e_dok) begin
      chk("rdata", k, rdat[k], h.d);
      qpop(k);
    end
    if (dok[k]) begin
      if (k == 0) begin dok0_c.push_back(cyc); dok0_d.push_back(rdat[0]); end
      else        begin dok1_c.push_back(cyc); dok1_d.push_back(rdat[1]); end
    end
    acc = pend[k] & e_aok;
    chk("ram_en", k, 32'(ren[k]), 32'(acc));
    chk("ram_we", k, 32'(rwe[k]), (acc && req_wr) ? 32'(req_wstrb) : 32'd0);
    if (pend[k] && aok[k]) begin
      if (k == 0) begin acc0_q.push_back(cyc); acc0_we = rwe[0]; acc0_ad = raddr[0]; end
      else        acc1_q.push_back(cyc);
    end
    if (acc) begin
      chk("ram_addr", k, 32'(raddr[k]), 32'(req_addr[RAW+1:2]));
      chk("ram_wdata", k, rwd[k], req_wdata);
      key = k * 65536 + int'(req_addr[RAW+1:2]);
      m = mmem.exists(key) ? mmem[key] : 32'd0;
      if (req_wr) begin
        for (int b = 0; b < 4; b++) if (req_wstrb[b]) m[8*b +: 8] = req_wdata[8*b +: 8];
        mmem[key] = m;
        r.d = 32'd0;
      end else begin
        r.d = m;
      end
      r.due = cyc + 2 + ((k == 0) ? 0 : 3);
      qpush(k, r);
    end
  endtask

  always @(negedge clk) begin
    model_step(0);
    model_step(1);
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic issue(input logic wr, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    int n;
    logic [1:0] acc;
    n = 0;
    req_wr = wr; req_addr = a; req_wstrb = s; req_wdata = d; pend = 2'b11;
    while (pend != 2'b00 && n < 200) begin
      @(negedge clk);
      acc = pend & aok;
      @(posedge clk); #1;
      pend = pend & ~acc;
      n++;
    end
    if (pend != 2'b00) begin
      total++; bad++;
      $display("FAIL issue_timeout addr=%h pend=%b want=00", a, pend);
      pend = 2'b00;
    end
  endtask

  task automatic clr_logs();
    acc0_q.delete(); acc1_q.delete(); dok0_c.delete(); dok1_c.delete();
    dok0_d.delete(); dok1_d.delete();
  endtask

  task automatic chk_reset(input int k);
    chk("rst_addr_ok", k, 32'(aok[k]), 32'd0);
    chk("rst_data_ok", k, 32'(dok[k]), 32'd0);
    chk("rst_rdata", k, rdat[k], 32'd0);
    chk("rst_ram_en", k, 32'(ren[k]), 32'd0);
    chk("rst_ram_we", k, 32'(rwe[k]), 32'd0);
    chk("rst_ram_addr", k, 32'(raddr[k]), 32'd0);
    chk("rst_ram_wdata", k, rwd[k], 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d want=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    pend = 2'b00; req_wr = 1'b0; req_addr = '0; req_wstrb = '0; req_wdata = '0;
    tick(3);
    chk_reset(0); chk_reset(1);
    @(posedge clk); #1 rstn = 1'b1;

    // idle
    tick(10);
    chk("idle_aok", 0, 32'(aok), 32'h3);
    chk("idle_dok", 0, 32'(dok), 32'h0);
    chk("idle_en", 0, 32'(ren), 32'h0);

    // word write, then word read
    clr_logs();
    issue(1'b1, 32'h1000, 4'hF, 32'hDEADBEEF);
    tick(6);
    chk("wr_acc_n", 0, acc0_q.size(), 1);
    chk("wr_we", 0, 32'(acc0_we), 32'hF);
    chk("wr_addr", 0, 32'(acc0_ad), 32'h400);
    chk("wr_lat", 0, (dok0_c.size() > 0 && acc0_q.size() > 0) ? dok0_c[0] - acc0_q[0] : -1, 2);
    chk("wr_rdata", 0, (dok0_d.size() > 0) ? dok0_d[0] : 32'hX, 32'h0);
    clr_logs();
    issue(1'b0, 32'h1000, 4'h0, 32'h0);
    tick(8);
    chk("rd_lat", 0, (dok0_c.size() > 0 && acc0_q.size() > 0) ? dok0_c[0] - acc0_q[0] : -1, 2);
    chk("rd_data", 0, (dok0_d.size() > 0) ? dok0_d[0] : 32'hX, 32'hDEADBEEF);
    chk("rd_lat", 1, (dok1_c.size() > 0 && acc1_q.size() > 0) ? dok1_c[0] - acc1_q[0] : -1, 5);
    chk("rd_data", 1, (dok1_d.size() > 0) ? dok1_d[0] : 32'hX, 32'hDEADBEEF);

    // byte write over the word, then read back
    clr_logs();
    issue(1'b1, 32'h1003, 4'b1000, 32'h5A5A5A5A);
    issue(1'b0, 32'h1000, 4'h0, 32'h0);
    tick(8);
    chk("byte_data", 0, (dok0_d.size() > 1) ? dok0_d[1] : 32'hX, 32'h5AADBEEF);
    chk("byte_data", 1, (dok1_d.size() > 1) ? dok1_d[1] : 32'hX, 32'h5AADBEEF);

    // preload 8 words, then 8 back-to-back reads
    for (int i = 0; i < 8; i++) issue(1'b1, 32'h2000 + 32'(4 * i), 4'hF, 32'h11110000 + 32'(i));
    tick(8);
    clr_logs();
    for (int i = 0; i < 8; i++) issue(1'b0, 32'h2000 + 32'(4 * i), 4'h0, 32'h0);
    tick(14);
    chk("b2b_nacc", 1, acc1_q.size(), 8);
    chk("b2b_ndok", 1, dok1_c.size(), 8);
    chk("b2b_ndok", 0, dok0_c.size(), 8);
    if (acc1_q.size() == 8 && dok1_c.size() == 8) begin
      chk("b2b_acc3", 1, acc1_q[3] - acc1_q[0], 3);
      chk("b2b_acc4", 1, acc1_q[4] - acc1_q[0], 6);
      chk("b2b_acc7", 1, acc1_q[7] - acc1_q[0], 9);
      chk("b2b_first_dok", 1, dok1_c[0] - acc1_q[0], 5);
      chk("b2b_reassert", 1, acc1_q[4] - dok1_c[0], 1);
      for (int i = 0; i < 8; i++) chk("b2b_data", 1, dok1_d[i], 32'h11110000 + 32'(i));
    end

    // async reset with reads outstanding
    clr_logs();
    issue(1'b0, 32'h2000, 4'h0, 32'h0);
    issue(1'b0, 32'h2004, 4'h0, 32'h0);
    issue(1'b0, 32'h2008, 4'h0, 32'h0);
    #1 rstn = 1'b0;
    #1 chk_reset(0); chk_reset(1);
    tick(2);
    @(posedge clk); #1 rstn = 1'b1;
    clr_logs();
    tick(10);
    chk("stale_dok", 0, dok0_c.size(), 0);
    chk("stale_dok", 1, dok1_c.size(), 0);
    issue(1'b0, 32'h2004, 4'h0, 32'h0);
    tick(8);
    chk("post_rst_data", 0, (dok0_d.size() > 0) ? dok0_d[0] : 32'hX, 32'h11110001);
    chk("post_rst_data", 1, (dok1_d.size() > 0) ? dok1_d[0] : 32'hX, 32'h11110001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
